// File: rtl/sram_arbiter_if.sv
// Bundle of both requester ports and the external async SRAM pad signals.
// The arbiter connects through the slave modport; requesters and pad logic connect through the master modport.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  io_p0_cmd_valid;
    logic                  io_p0_cmd_ready;
    logic                  io_p0_cmd_write;
    logic [ADDR_WIDTH-2:0] io_p0_cmd_addr;
    logic [31:0]           io_p0_cmd_wdata;
    logic [3:0]            io_p0_cmd_mask;
    logic                  io_p0_rsp_valid;
    logic [31:0]           io_p0_rsp_rdata;

    logic                  io_p1_cmd_valid;
    logic                  io_p1_cmd_ready;
    logic                  io_p1_cmd_write;
    logic [ADDR_WIDTH-2:0] io_p1_cmd_addr;
    logic [31:0]           io_p1_cmd_wdata;
    logic [3:0]            io_p1_cmd_mask;
    logic                  io_p1_rsp_valid;
    logic [31:0]           io_p1_rsp_rdata;

    logic [ADDR_WIDTH-1:0] io_sram_addr;
    logic [15:0]           io_sram_dat_read;
    logic [15:0]           io_sram_dat_write;
    logic                  io_sram_dat_writeEnable;
    logic                  io_sram_cs;
    logic                  io_sram_we;
    logic                  io_sram_oe;
    logic                  io_sram_ub;
    logic                  io_sram_lb;

    modport slave (
        input  io_p0_cmd_valid, io_p0_cmd_write, io_p0_cmd_addr, io_p0_cmd_wdata, io_p0_cmd_mask,
        output io_p0_cmd_ready, io_p0_rsp_valid, io_p0_rsp_rdata,
        input  io_p1_cmd_valid, io_p1_cmd_write, io_p1_cmd_addr, io_p1_cmd_wdata, io_p1_cmd_mask,
        output io_p1_cmd_ready, io_p1_rsp_valid, io_p1_rsp_rdata,
        input  io_sram_dat_read,
        output io_sram_addr, io_sram_dat_write, io_sram_dat_writeEnable,
        output io_sram_cs, io_sram_we, io_sram_oe, io_sram_ub, io_sram_lb
    );

    modport master (
        output io_p0_cmd_valid, io_p0_cmd_write, io_p0_cmd_addr, io_p0_cmd_wdata, io_p0_cmd_mask,
        input  io_p0_cmd_ready, io_p0_rsp_valid, io_p0_rsp_rdata,
        output io_p1_cmd_valid, io_p1_cmd_write, io_p1_cmd_addr, io_p1_cmd_wdata, io_p1_cmd_mask,
        input  io_p1_cmd_ready, io_p1_rsp_valid, io_p1_rsp_rdata,
        output io_sram_dat_read,
        input  io_sram_addr, io_sram_dat_write, io_sram_dat_writeEnable,
        input  io_sram_cs, io_sram_we, io_sram_oe, io_sram_ub, io_sram_lb
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a 16-bit async SRAM: each 32-bit access runs as a LO then HI halfword phase.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
// Handshake: a command transfers in the cycle where cmd_valid && cmd_ready; ready is a one-cycle pulse
// in IDLE, and the requester keeps its command fields stable while valid && !ready.
module sram_arbiter #(
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          io_mainClk,
    input  logic          io_reset,
    sram_arbiter_if.slave bus,
    output logic [1:0]    dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-2:0] cmd_addr_q, cmd_addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            mask_q, mask_d;
    logic [15:0]           lo_q, lo_d;
    logic [31:0]           rdata0_q, rdata0_d;
    logic [31:0]           rdata1_q, rdata1_d;

    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]           dat_q, dat_d;
    logic                  wen_q, wen_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  ub_q, ub_d;
    logic                  lb_q, lb_d;

    logic gnt0, gnt1, take, phase;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = bus.io_p0_cmd_valid;
        gnt1 = bus.io_p1_cmd_valid && !bus.io_p0_cmd_valid;
    end
`else
    // last_q names the port granted most recently; resets to 1 so port 0 wins the first tie.
    logic last_q, last_d;

    always_comb begin
        gnt0   = bus.io_p0_cmd_valid && (!bus.io_p1_cmd_valid || last_q);
        gnt1   = bus.io_p1_cmd_valid && (!bus.io_p0_cmd_valid || !last_q);
        last_d = (take && !io_reset) ? gnt1 : last_q;
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) last_q <= 1'b1;
        else          last_q <= last_d;
    end
`endif

    assign take = (state_q == ST_IDLE) && (gnt0 || gnt1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        write_d    = write_q;
        cmd_addr_d = cmd_addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        lo_d       = lo_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d    = ST_LO;
                    cnt_d      = 4'd0;
                    port_d     = gnt1;
                    write_d    = gnt1 ? bus.io_p1_cmd_write : bus.io_p0_cmd_write;
                    cmd_addr_d = gnt1 ? bus.io_p1_cmd_addr  : bus.io_p0_cmd_addr;
                    wdata_d    = gnt1 ? bus.io_p1_cmd_wdata : bus.io_p0_cmd_wdata;
                    mask_d     = gnt1 ? bus.io_p1_cmd_mask  : bus.io_p0_cmd_mask;
                end
            end
            ST_LO: begin
                if (cnt_q == W_LAST) begin
                    state_d = ST_HI;
                    cnt_d   = 4'd0;
                    if (!write_q) lo_d = bus.io_sram_dat_read;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HI: begin
                if (cnt_q == W_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    if (!write_q && port_q)  rdata1_d = {bus.io_sram_dat_read, lo_q};
                    if (!write_q && !port_q) rdata0_d = {bus.io_sram_dat_read, lo_q};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad values are derived from the next state so the registered pins line up with the phase they belong to.
    always_comb begin
        phase       = (state_d == ST_HI);
        sram_addr_d = '0;
        dat_d       = 16'h0000;
        wen_d       = 1'b0;
        cs_d        = 1'b1;
        we_d        = 1'b1;
        oe_d        = 1'b1;
        ub_d        = 1'b1;
        lb_d        = 1'b1;
        if (state_d == ST_LO || state_d == ST_HI) begin
            cs_d        = 1'b0;
            sram_addr_d = {cmd_addr_d, phase};
            if (write_d) begin
                wen_d = 1'b1;
                we_d  = (cnt_d == W_LAST);
                dat_d = phase ? wdata_d[31:16] : wdata_d[15:0];
                lb_d  = phase ? ~mask_d[2] : ~mask_d[0];
                ub_d  = phase ? ~mask_d[3] : ~mask_d[1];
            end else begin
                oe_d = 1'b0;
                ub_d = 1'b0;
                lb_d = 1'b0;
            end
        end
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            port_q      <= 1'b0;
            write_q     <= 1'b0;
            cmd_addr_q  <= '0;
            wdata_q     <= 32'h0;
            mask_q      <= 4'h0;
            lo_q        <= 16'h0;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
            sram_addr_q <= '0;
            dat_q       <= 16'h0;
            wen_q       <= 1'b0;
            cs_q        <= 1'b1;
            we_q        <= 1'b1;
            oe_q        <= 1'b1;
            ub_q        <= 1'b1;
            lb_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            write_q     <= write_d;
            cmd_addr_q  <= cmd_addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            lo_q        <= lo_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            sram_addr_q <= sram_addr_d;
            dat_q       <= dat_d;
            wen_q       <= wen_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            ub_q        <= ub_d;
            lb_q        <= lb_d;
        end
    end

    // A command is not accepted during reset since nothing would be latched.
    assign bus.io_p0_cmd_ready = take && gnt0 && !io_reset;
    assign bus.io_p1_cmd_ready = take && gnt1 && !io_reset;
    assign bus.io_p0_rsp_valid = (state_q == ST_DONE) && !port_q;
    assign bus.io_p1_rsp_valid = (state_q == ST_DONE) && port_q;
    assign bus.io_p0_rsp_rdata = rdata0_q;
    assign bus.io_p1_rsp_rdata = rdata1_q;

    assign bus.io_sram_addr            = sram_addr_q;
    assign bus.io_sram_dat_write       = dat_q;
    assign bus.io_sram_dat_writeEnable = wen_q;
    assign bus.io_sram_cs              = cs_q;
    assign bus.io_sram_we              = we_q;
    assign bus.io_sram_oe              = oe_q;
    assign bus.io_sram_ub              = ub_q;
    assign bus.io_sram_lb              = lb_q;
    assign dbg_state_o                 = state_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3,
// each connected to a small behavioural SRAM.
module tb_sram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3, sel3;
    logic v0, v1, wr0, wr1;
    logic [16:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0] m0, m1;
    logic [1:0] st1, st3;

    int n_checks = 0;
    int n_pass   = 0;

    sram_arbiter_if #(.ADDR_WIDTH(18)) bus1 ();
    sram_arbiter_if #(.ADDR_WIDTH(18)) bus3 ();

    sram_arbiter #(.ADDR_WIDTH(18), .WAIT_CYCLES(1)) u_dut1 (
        .io_mainClk(clk), .io_reset(rst1), .bus(bus1), .dbg_state_o(st1));
    sram_arbiter #(.ADDR_WIDTH(18), .WAIT_CYCLES(3)) u_dut3 (
        .io_mainClk(clk), .io_reset(rst3), .bus(bus3), .dbg_state_o(st3));

    assign bus1.io_p0_cmd_valid = v0 && !sel3;
    assign bus1.io_p0_cmd_write = wr0;
    assign bus1.io_p0_cmd_addr  = a0;
    assign bus1.io_p0_cmd_wdata = d0;
    assign bus1.io_p0_cmd_mask  = m0;
    assign bus1.io_p1_cmd_valid = v1 && !sel3;
    assign bus1.io_p1_cmd_write = wr1;
    assign bus1.io_p1_cmd_addr  = a1;
    assign bus1.io_p1_cmd_wdata = d1;
    assign bus1.io_p1_cmd_mask  = m1;

    assign bus3.io_p0_cmd_valid = v0 && sel3;
    assign bus3.io_p0_cmd_write = wr0;
    assign bus3.io_p0_cmd_addr  = a0;
    assign bus3.io_p0_cmd_wdata = d0;
    assign bus3.io_p0_cmd_mask  = m0;
    assign bus3.io_p1_cmd_valid = 1'b0;
    assign bus3.io_p1_cmd_write = 1'b0;
    assign bus3.io_p1_cmd_addr  = '0;
    assign bus3.io_p1_cmd_wdata = 32'h0;
    assign bus3.io_p1_cmd_mask  = 4'h0;

    // Behavioural SRAMs: writes land at the edge ending a cycle with cs and we low.
    logic [15:0] mem1 [0:1023];
    logic [15:0] mem3 [0:1023];

    always @(posedge clk) begin
        if (!bus1.io_sram_cs && !bus1.io_sram_we) begin
            if (!bus1.io_sram_lb) mem1[bus1.io_sram_addr[9:0]][7:0]  <= bus1.io_sram_dat_write[7:0];
            if (!bus1.io_sram_ub) mem1[bus1.io_sram_addr[9:0]][15:8] <= bus1.io_sram_dat_write[15:8];
        end
    end

    always @(negedge clk) begin
        bus1.io_sram_dat_read <= (!bus1.io_sram_cs && !bus1.io_sram_oe) ? mem1[bus1.io_sram_addr[9:0]] : 16'h0;
        bus3.io_sram_dat_read <= (!bus3.io_sram_cs && !bus3.io_sram_oe) ? mem3[bus3.io_sram_addr[9:0]] : 16'h0;
    end

    logic        o_ready0, o_ready1, o_rsp0, o_rsp1;
    logic [31:0] o_rdata0, o_rdata1;
    logic [17:0] o_addr;
    logic [15:0] o_dat;
    logic [5:0]  o_strb;

    always_comb begin
        o_ready0 = sel3 ? bus3.io_p0_cmd_ready : bus1.io_p0_cmd_ready;
        o_ready1 = sel3 ? bus3.io_p1_cmd_ready : bus1.io_p1_cmd_ready;
        o_rsp0   = sel3 ? bus3.io_p0_rsp_valid : bus1.io_p0_rsp_valid;
        o_rsp1   = sel3 ? bus3.io_p1_rsp_valid : bus1.io_p1_rsp_valid;
        o_rdata0 = sel3 ? bus3.io_p0_rsp_rdata : bus1.io_p0_rsp_rdata;
        o_rdata1 = sel3 ? bus3.io_p1_rsp_rdata : bus1.io_p1_rsp_rdata;
        o_addr   = sel3 ? bus3.io_sram_addr : bus1.io_sram_addr;
        o_dat    = sel3 ? bus3.io_sram_dat_write : bus1.io_sram_dat_write;
        o_strb   = sel3 ? {bus3.io_sram_cs, bus3.io_sram_we, bus3.io_sram_oe, bus3.io_sram_ub,
                           bus3.io_sram_lb, bus3.io_sram_dat_writeEnable}
                        : {bus1.io_sram_cs, bus1.io_sram_we, bus1.io_sram_oe, bus1.io_sram_ub,
                           bus1.io_sram_lb, bus1.io_sram_dat_writeEnable};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Called just after a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    // Strobe vector order is {cs, we, oe, ub, lb, writeEnable}.
    task automatic run_op(input string name, input logic port, input logic wr, input logic [16:0] addr,
                          input logic [31:0] wd, input logic [3:0] m, input int w,
                          input logic [31:0] exp_rdata);
        logic       ph;
        int         c;
        logic [5:0] exp_s;
        if (port) begin v1 = 1'b1; wr1 = wr; a1 = addr; d1 = wd; m1 = m; end
        else      begin v0 = 1'b1; wr0 = wr; a0 = addr; d0 = wd; m0 = m; end
        #1;
        check({name, "_grant"}, {30'd0, o_ready1, o_ready0}, port ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        for (int k = 1; k <= 2 * w + 3; k++) begin
            @(negedge clk);
            if (k <= 2 * w + 2) begin
                ph = (k > w + 1);
                c  = ph ? k - (w + 2) : k - 1;
                if (wr) exp_s = {1'b0, (c == w), 1'b1, ph ? ~m[3] : ~m[1], ph ? ~m[2] : ~m[0], 1'b1};
                else    exp_s = 6'b010000;
                check($sformatf("%s_strb_c%0d", name, k), o_strb, exp_s);
                check($sformatf("%s_addr_c%0d", name, k), o_addr, {addr, ph});
                check($sformatf("%s_rsp_c%0d", name, k), {o_rsp1, o_rsp0}, 2'b00);
                if (wr) check($sformatf("%s_dat_c%0d", name, k), o_dat, ph ? wd[31:16] : wd[15:0]);
            end else begin
                check({name, "_done_rsp"}, {o_rsp1, o_rsp0}, port ? 2'b10 : 2'b01);
                check({name, "_done_strb"}, o_strb, 6'b111110);
                if (!wr) check({name, "_rdata"}, port ? o_rdata1 : o_rdata0, exp_rdata);
            end
        end
        @(negedge clk);
        check({name, "_idle_rsp"}, {o_rsp1, o_rsp0}, 2'b00);
        check({name, "_idle_strb"}, o_strb, 6'b111110);
    endtask

    logic rsp_seen;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 16'h0000;
            mem3[i] = 16'h0000;
        end
        mem3[6] = 16'h5678;
        mem3[7] = 16'h1234;
        sel3 = 1'b0;
        v0 = 1'b0; v1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; m0 = '0; m1 = '0;
        rst1 = 1'b1;
        rst3 = 1'b1;

        // Reset state, with a request held during reset that must not be accepted
        repeat (2) @(negedge clk);
        v0 = 1'b1;
        #1;
        check("rst_ready", {o_ready1, o_ready0}, 2'b00);
        check("rst_strb", o_strb, 6'b111110);
        check("rst_addr", o_addr, 18'h0);
        check("rst_dat", o_dat, 16'h0);
        check("rst_rsp", {o_rsp1, o_rsp0}, 2'b00);
        check("rst_rdata0", o_rdata0, 32'h0);
        check("rst_rdata1", o_rdata1, 32'h0);
        check("rst_state", st1, 2'd0);
        v0 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        run_op("t1_wr", 1'b0, 1'b1, 17'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0);
        run_op("t2_rd", 1'b0, 1'b0, 17'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF);
        run_op("t3_wr", 1'b1, 1'b1, 17'h10, 32'h0000AB00, 4'h2, 1, 32'h0);
        run_op("t3_rd", 1'b1, 1'b0, 17'h10, 32'h0, 4'h0, 1, 32'hDEADABEF);
        check("t3_rdata0_held", o_rdata0, 32'hDEADBEEF);
        run_op("m0_wr", 1'b0, 1'b1, 17'h11, 32'hFFFFFFFF, 4'h0, 1, 32'h0);
        run_op("m0_rd", 1'b0, 1'b0, 17'h11, 32'h0, 4'h0, 1, 32'h0);

        // Reset during the LO phase of a write
        v0 = 1'b1; wr0 = 1'b1; a0 = 17'h50; d0 = 32'h12345678; m0 = 4'hF;
        #1;
        check("t5_ready", o_ready0, 1'b1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        @(negedge clk);
        check("t5_lo_cswe", o_strb[5:4], 2'b00);
        rst1 = 1'b1;
        @(negedge clk);
        check("t5_strb", o_strb, 6'b111110);
        check("t5_rsp", o_rsp0, 1'b0);
        check("t5_state", st1, 2'd0);
        rst1 = 1'b0;
        rsp_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            rsp_seen = rsp_seen | o_rsp0 | o_rsp1;
        end
        check("t5_no_rsp", rsp_seen, 1'b0);

        // Both ports requesting continuously (pointer freshly reset)
        v0 = 1'b1; wr0 = 1'b0; a0 = 17'h10;
        v1 = 1'b1; wr1 = 1'b0; a1 = 17'h10;
        for (int t = 0; t < 24; t++) begin
            #1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
            check($sformatf("t4_grant_t%0d", t), {o_ready1, o_ready0}, {1'b0, (t % 6) == 0});
`else
            check($sformatf("t4_grant_t%0d", t), {o_ready1, o_ready0}, {(t % 12) == 6, (t % 12) == 0});
`endif
            @(negedge clk);
        end
        v0 = 1'b0;
        v1 = 1'b0;
        check("t4_rdata0", o_rdata0, 32'hDEADABEF);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        check("t4_rdata1", o_rdata1, 32'h0);
`else
        check("t4_rdata1", o_rdata1, 32'hDEADABEF);
`endif
        @(negedge clk);
        run_op("post_rd", 1'b1, 1'b0, 17'h10, 32'h0, 4'h0, 1, 32'hDEADABEF);

        // Longer phases on the WAIT_CYCLES=3 instance
        sel3 = 1'b1;
        @(negedge clk);
        run_op("t6_rd", 1'b0, 1'b0, 17'h3, 32'h0, 4'h0, 3, 32'h12345678);
        check("t6_state", st3, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
